result_stream_unloader: RTL and testbench

- Downstream of the pairing core's `top`, on the result side.
- Drives `top`'s read-select handshake (`I_INPUTMODE` = `REF_RESULT` and `I_RADDR`) over a run of consecutive RAM addresses.
- After the core's read latency, captures the 24 parallel result lanes (`result0000`..`result1211`) into a buffer.
- Streams the buffer out one word per beat on a valid/ready interface toward the host/AXI bridge.

---
 rtl/result_stream_unloader.sv | 191 +++++++++++++++++++
 tb/tb_result_stream_unloader.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_stream_unloader.sv
// result_stream_unloader
// Reads a run of consecutive result RAM addresses from the pairing core.
// For each address it waits for the core to go idle and selects REF_RESULT
// at that address. After the read latency it captures all result lanes and
// streams them out one word per beat.
// Optional: define RSTREAM_CHECKSUM_EN to append one XOR-checksum beat
// (m_lane = 31) after the lanes of every address.
//
// Stream handshake: a beat transfers on every rising clk edge where
// m_valid & m_ready. Once m_valid is raised, m_data/m_lane/m_last hold
// until that transfer. m_valid never depends combinationally on m_ready.
module result_stream_unloader #(
    parameter int WORD_SIZE      = 64,
    parameter int NUM_LANES      = 24,
    parameter int RAM_ADDR_SIZE  = 8,
    parameter int READ_LATENCY   = 3,
    parameter int INPUTMODE_SIZE = 3,
    parameter logic [INPUTMODE_SIZE-1:0] REF_RESULT_CODE = 3'd4,
    parameter logic [INPUTMODE_SIZE-1:0] IDLE_MODE_CODE  = 3'd0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [RAM_ADDR_SIZE-1:0]       start_raddr,
    input  logic [RAM_ADDR_SIZE-1:0]       num_addrs,
    input  logic                           core_busy,
    input  logic [NUM_LANES*WORD_SIZE-1:0] result_lanes,
    output logic [INPUTMODE_SIZE-1:0]      o_inputmode,
    output logic [RAM_ADDR_SIZE-1:0]       o_raddr,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [WORD_SIZE-1:0]           m_data,
    output logic [4:0]                     m_lane,
    output logic                           m_last,
    output logic                           busy,
    output logic                           done
);

    localparam int CNT_W = $clog2(READ_LATENCY + 1);
    localparam logic [4:0] LAST_LANE = 5'(NUM_LANES - 1);
`ifdef RSTREAM_CHECKSUM_EN
    localparam logic [4:0] CHK_LANE   = 5'd31;
    localparam logic [4:0] FINAL_LANE = CHK_LANE;
`else
    localparam logic [4:0] FINAL_LANE = LAST_LANE;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_CORE,
        S_LATENCY,
        S_CAPTURE,
        S_STREAM,
        S_DONE
    } state_t;

    state_t                   state;
    logic [RAM_ADDR_SIZE-1:0] cur_addr;
    logic [RAM_ADDR_SIZE-1:0] rem;
    logic [CNT_W-1:0]         lat_cnt;
    logic [4:0]               lane_idx;
    logic                     m_valid_q;
    logic [WORD_SIZE-1:0]     buf_q [NUM_LANES];
    logic                     addr_end;
    logic                     last_addr;

    assign addr_end  = m_valid_q && m_ready && (lane_idx == FINAL_LANE);
    assign last_addr = (rem == RAM_ADDR_SIZE'(1));
    assign m_valid   = m_valid_q;
    assign m_lane    = lane_idx;
    assign m_last    = m_valid_q && (lane_idx == FINAL_LANE) && last_addr;

`ifdef RSTREAM_CHECKSUM_EN
    logic [WORD_SIZE-1:0] lane_xor;
    logic [WORD_SIZE-1:0] chk_q;

    // XOR of all incoming lanes, captured alongside the lane buffer
    always_comb begin
        lane_xor = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_xor = lane_xor ^ result_lanes[i*WORD_SIZE +: WORD_SIZE];
        end
    end

    // Select the checksum word on the extra beat, a buffered lane otherwise
    always_comb begin
        m_data = '0;
        if (m_valid_q) begin
            if (lane_idx == CHK_LANE) begin
                m_data = chk_q;
            end else begin
                m_data = buf_q[lane_idx];
            end
        end
    end
`else
    // Present the buffered lane selected by the lane index
    always_comb begin
        m_data = '0;
        if (m_valid_q) begin
            m_data = buf_q[lane_idx];
        end
    end
`endif

    // Lane buffer: loaded once per address in CAPTURE, needs no reset
    always_ff @(posedge clk) begin
        if (state == S_CAPTURE) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                buf_q[i] <= result_lanes[i*WORD_SIZE +: WORD_SIZE];
            end
`ifdef RSTREAM_CHECKSUM_EN
            chk_q <= lane_xor;
`endif
        end
    end

    // Control FSM with registered read-select, valid, busy and done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            o_inputmode <= IDLE_MODE_CODE;
            o_raddr     <= '0;
            cur_addr    <= '0;
            rem         <= '0;
            lat_cnt     <= '0;
            lane_idx    <= '0;
            m_valid_q   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                // DONE already has busy low, so a start there is accepted too
                S_IDLE, S_DONE: begin
                    state <= S_IDLE;
                    if (start) begin
                        cur_addr <= start_raddr;
                        rem      <= (num_addrs == '0) ? RAM_ADDR_SIZE'(1) : num_addrs;
                        busy     <= 1'b1;
                        state    <= S_WAIT_CORE;
                    end
                end
                S_WAIT_CORE: begin
                    if (!core_busy) begin
                        o_inputmode <= REF_RESULT_CODE;
                        o_raddr     <= cur_addr;
                        lat_cnt     <= CNT_W'(READ_LATENCY);
                        state       <= S_LATENCY;
                    end
                end
                // The read is committed here; core_busy is deliberately ignored
                S_LATENCY: begin
                    lat_cnt <= lat_cnt - CNT_W'(1);
                    if (lat_cnt == CNT_W'(1)) begin
                        state <= S_CAPTURE;
                    end
                end
                // Release the core as soon as the lanes are buffered
                S_CAPTURE: begin
                    lane_idx    <= '0;
                    m_valid_q   <= 1'b1;
                    o_inputmode <= IDLE_MODE_CODE;
                    state       <= S_STREAM;
                end
                S_STREAM: begin
                    if (addr_end) begin
                        m_valid_q <= 1'b0;
                        if (last_addr) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            cur_addr <= cur_addr + RAM_ADDR_SIZE'(1);
                            rem      <= rem - RAM_ADDR_SIZE'(1);
                            state    <= S_WAIT_CORE;
                        end
                    end else if (m_ready) begin
`ifdef RSTREAM_CHECKSUM_EN
                        lane_idx <= (lane_idx == LAST_LANE) ? CHK_LANE : lane_idx + 5'd1;
`else
                        lane_idx <= lane_idx + 5'd1;
`endif
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_result_stream_unloader.sv
// tb_result_stream_unloader
// Directed bench for result_stream_unloader. A small core model returns
// lane words that encode the RAM address, delayed by the read latency,
// so wrong addresses or early captures show up as wrong data.
// Build with RSTREAM_CHECKSUM_EN defined to cover the checksum beat.
module tb_result_stream_unloader;

    localparam int W  = 64;
    localparam int NL = 24;
`ifdef RSTREAM_CHECKSUM_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif
    localparam int BEATS    = NL + EXTRA;
    localparam int PER_ADDR = 5 + BEATS;

    // ---------------- clock / reset / DUT ----------------
    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [7:0]      start_raddr;
    logic [7:0]      num_addrs;
    logic            core_busy;
    logic [NL*W-1:0] result_lanes;
    logic [2:0]      o_inputmode;
    logic [7:0]      o_raddr;
    logic            m_valid;
    logic            m_ready;
    logic [W-1:0]    m_data;
    logic [4:0]      m_lane;
    logic            m_last;
    logic            busy;
    logic            done;

    always #5 clk = ~clk;

    result_stream_unloader dut (
        .clk(clk), .rst(rst), .start(start), .start_raddr(start_raddr),
        .num_addrs(num_addrs), .core_busy(core_busy), .result_lanes(result_lanes),
        .o_inputmode(o_inputmode), .o_raddr(o_raddr), .m_valid(m_valid),
        .m_ready(m_ready), .m_data(m_data), .m_lane(m_lane), .m_last(m_last),
        .busy(busy), .done(done)
    );

    int checks = 0;
    int errors = 0;
    bit lane_tag;

    function automatic logic [63:0] lane_word(input logic [7:0] addr, input bit tag, input int i);
        logic [63:0] w;
        w = 64'(256 + i);
        if (tag) w = w | ({56'h0, addr} << 32);
        return w;
    endfunction

    // ---------------- core model: address/mode pipeline ----------------
    logic [7:0] addr_p1, addr_p2, addr_p3;
    logic [2:0] mode_p1, mode_p2, mode_p3;

    always @(posedge clk) begin
        addr_p1 <= o_raddr;     addr_p2 <= addr_p1; addr_p3 <= addr_p2;
        mode_p1 <= o_inputmode; mode_p2 <= mode_p1; mode_p3 <= mode_p2;
    end

    always_comb begin
        result_lanes = '0;
        for (int i = 0; i < NL; i++) begin
            result_lanes[i*W +: W] = (mode_p3 == 3'd4) ? lane_word(addr_p3, lane_tag, i)
                                                       : (64'hDEAD_0000_0000_0000 | 64'(i));
        end
    end

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    logic [4:0]   exp_lane_q[$];
    logic [W-1:0] got_data[$];
    logic [4:0]   got_lane[$];
    logic         got_last[$];
    logic [7:0]   raddr_q[$];
    int           done_cyc, first_ref_cyc, stall_err, mode_err, wait_err, busy_gap;
    logic         busy_at_done;

    task automatic build_exp(input logic [7:0] a0, input int n, input bit tag);
        logic [7:0]  a;
        logic [63:0] w, x;
        exp_q.delete();
        exp_lane_q.delete();
        for (int k = 0; k < n; k++) begin
            a = a0 + 8'(k);
            x = '0;
            for (int i = 0; i < NL; i++) begin
                w = lane_word(a, tag, i);
                x = x ^ w;
                exp_q.push_back(w);
                exp_lane_q.push_back(5'(i));
            end
            if (EXTRA != 0) begin
                exp_q.push_back(x);
                exp_lane_q.push_back(5'd31);
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_start(input logic [7:0] a, input logic [7:0] n);
        @(posedge clk); #1;
        start = 1'b1; start_raddr = a; num_addrs = n;
    endtask

    // Runs from the start cycle (cyc 0) until done or max_cyc; records beats
    // and protocol observations. Observation at cyc k reflects edge k-1.
    task automatic collect(input int max_cyc, input int ready_mode,
                           input int busy_cycles, input int glitch_cyc);
        logic         pv, pr, pl;
        logic [W-1:0] pd;
        logic [4:0]   pn;
        logic [2:0]   pm;
        logic [7:0]   raddr0;
        got_data.delete(); got_lane.delete(); got_last.delete(); raddr_q.delete();
        done_cyc = -1; first_ref_cyc = -1; stall_err = 0; mode_err = 0;
        wait_err = 0; busy_gap = 0; busy_at_done = 1'b1;
        pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0; pn = '0; pm = 3'd0;
        raddr0 = o_raddr;
        for (int cyc = 0; cyc <= max_cyc; cyc++) begin
            if (cyc > 0) begin
                @(posedge clk); #1;
                start = (cyc == glitch_cyc);
                if (start) begin start_raddr = 8'h55; num_addrs = 8'd7; end
            end
            core_busy = (cyc <= busy_cycles);
            m_ready   = (ready_mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            @(negedge clk);
            if (o_inputmode == 3'd4 && pm != 3'd4) begin
                raddr_q.push_back(o_raddr);
                if (first_ref_cyc < 0) first_ref_cyc = cyc - 1;
            end
            if (cyc >= 1 && first_ref_cyc < 0 && (o_raddr !== raddr0 || o_inputmode !== 3'd0))
                wait_err++;
            if (m_valid && o_inputmode !== 3'd0) mode_err++;
            if (pv && !pr && (!m_valid || m_data !== pd || m_lane !== pn || m_last !== pl))
                stall_err++;
            if (m_valid && m_ready) begin
                got_data.push_back(m_data);
                got_lane.push_back(m_lane);
                got_last.push_back(m_last);
            end
            if (done) begin
                done_cyc = cyc - 1;
                busy_at_done = busy;
                break;
            end
            if (cyc >= 1 && !busy) busy_gap++;
            pv = m_valid; pr = m_ready; pd = m_data; pn = m_lane; pl = m_last; pm = o_inputmode;
        end
        start = 1'b0; core_busy = 1'b0; m_ready = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst = 1'b1; start = 1'b0; start_raddr = '0; num_addrs = '0;
        core_busy = 1'b0; m_ready = 1'b1; lane_tag = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (o_inputmode !== 3'd0 || o_raddr !== 8'h00) begin
            errors++;
            $display("FAIL reset_sel mode %0d raddr %h, want 0 00", o_inputmode, o_raddr);
        end
        checks++;
        if ({m_valid, m_last, busy, done} !== 4'b0 || m_data !== '0 || m_lane !== 5'd0) begin
            errors++;
            $display("FAIL reset_out valid/last/busy/done %b data %h lane %0d, want all 0",
                     {m_valid, m_last, busy, done}, m_data, m_lane);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_single;
        lane_tag = 1'b0;
        build_exp(8'h10, 1, 1'b0);
        drive_start(8'h10, 8'd1);
        collect(200, 0, 0, 0);
        checks++;
        if (got_data.size() != exp_q.size()) begin
            errors++; $display("FAIL single_count got %0d want %0d", got_data.size(), exp_q.size());
        end
        for (int j = 0; j < got_data.size() && j < exp_q.size(); j++) begin
            checks++;
            if (got_data[j] !== exp_q[j] || got_lane[j] !== exp_lane_q[j] || got_last[j] !== (j == exp_q.size() - 1)) begin
                errors++;
                $display("FAIL single_beat%0d got %h/%0d/%0b want %h/%0d/%0b", j, got_data[j], got_lane[j],
                         got_last[j], exp_q[j], exp_lane_q[j], (j == exp_q.size() - 1));
            end
        end
        checks++;
        if (raddr_q.size() != 1 || raddr_q[0] !== 8'h10) begin
            errors++; $display("FAIL single_raddr got %0d reads, want one read of 10", raddr_q.size());
        end
        checks++;
        if (done_cyc != PER_ADDR) begin
            errors++; $display("FAIL single_done_latency got %0d want %0d", done_cyc, PER_ADDR);
        end
        checks++;
        if (busy_gap != 0 || busy_at_done !== 1'b0 || mode_err != 0) begin
            errors++;
            $display("FAIL single_flags busy_gap %0d busy_at_done %0b mode_err %0d, want 0 0 0",
                     busy_gap, busy_at_done, mode_err);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || m_valid !== 1'b0 || o_inputmode !== 3'd0) begin
            errors++;
            $display("FAIL single_idle busy %0b done %0b valid %0b mode %0d, want 0 0 0 0",
                     busy, done, m_valid, o_inputmode);
        end
    endtask

    task automatic test_core_busy;
        lane_tag = 1'b1;
        build_exp(8'h40, 1, 1'b1);
        drive_start(8'h40, 8'd1);
        collect(200, 0, 10, 0);
        checks++;
        if (first_ref_cyc != 11 || wait_err != 0) begin
            errors++;
            $display("FAIL busy_wait first read at %0d wait_err %0d, want 11 0", first_ref_cyc, wait_err);
        end
        checks++;
        if (done_cyc != PER_ADDR + 10) begin
            errors++; $display("FAIL busy_done got %0d want %0d", done_cyc, PER_ADDR + 10);
        end
        checks++;
        if (got_data.size() != exp_q.size() || got_data[0] !== exp_q[0] || got_data[got_data.size()-1] !== exp_q[exp_q.size()-1]) begin
            errors++;
            $display("FAIL busy_data count %0d first %h, want %0d %h", got_data.size(),
                     (got_data.size() > 0) ? got_data[0] : 64'h0, exp_q.size(), exp_q[0]);
        end
    endtask

    task automatic test_backpressure;
        lane_tag = 1'b1;
        build_exp(8'h50, 1, 1'b1);
        drive_start(8'h50, 8'd1);
        collect(400, 1, 0, 0);
        checks++;
        if (got_data.size() != exp_q.size() || done_cyc < 0) begin
            errors++; $display("FAIL bp_count got %0d done_cyc %0d want %0d done", got_data.size(), done_cyc, exp_q.size());
        end
        for (int j = 0; j < got_data.size() && j < exp_q.size(); j++) begin
            checks++;
            if (got_data[j] !== exp_q[j] || got_lane[j] !== exp_lane_q[j]) begin
                errors++;
                $display("FAIL bp_beat%0d got %h/%0d want %h/%0d", j, got_data[j], got_lane[j], exp_q[j], exp_lane_q[j]);
            end
        end
        checks++;
        if (stall_err != 0 || mode_err != 0) begin
            errors++; $display("FAIL bp_stall stall_err %0d mode_err %0d want 0 0", stall_err, mode_err);
        end
    endtask

    task automatic test_multi_wrap;
        int last_cnt;
        lane_tag = 1'b1;
        build_exp(8'hFE, 3, 1'b1);
        drive_start(8'hFE, 8'd3);
        collect(600, 0, 0, 40);  // start pulse at cyc 40 must be ignored
        checks++;
        if (got_data.size() != exp_q.size()) begin
            errors++; $display("FAIL wrap_count got %0d want %0d", got_data.size(), exp_q.size());
        end
        last_cnt = 0;
        for (int j = 0; j < got_data.size() && j < exp_q.size(); j++) begin
            if (got_last[j]) last_cnt++;
            checks++;
            if (got_data[j] !== exp_q[j] || got_lane[j] !== exp_lane_q[j] || got_last[j] !== (j == exp_q.size() - 1)) begin
                errors++;
                $display("FAIL wrap_beat%0d got %h/%0d/%0b want %h/%0d/%0b", j, got_data[j], got_lane[j],
                         got_last[j], exp_q[j], exp_lane_q[j], (j == exp_q.size() - 1));
            end
        end
        checks++;
        if (last_cnt != 1) begin
            errors++; $display("FAIL wrap_last_count got %0d want 1", last_cnt);
        end
        checks++;
        if (raddr_q.size() != 3 || raddr_q[0] !== 8'hFE || raddr_q[1] !== 8'hFF || raddr_q[2] !== 8'h00) begin
            errors++; $display("FAIL wrap_raddr got %0d reads, want FE FF 00", raddr_q.size());
        end
        checks++;
        if (done_cyc != 3 * PER_ADDR) begin
            errors++; $display("FAIL wrap_done got %0d want %0d", done_cyc, 3 * PER_ADDR);
        end
    endtask

    task automatic test_zero_count;
        lane_tag = 1'b1;
        build_exp(8'h60, 1, 1'b1);
        drive_start(8'h60, 8'd0);
        collect(200, 0, 0, 0);
        checks++;
        if (got_data.size() != exp_q.size() || done_cyc != PER_ADDR || raddr_q.size() != 1) begin
            errors++;
            $display("FAIL zero_count beats %0d done %0d reads %0d, want %0d %0d 1",
                     got_data.size(), done_cyc, raddr_q.size(), exp_q.size(), PER_ADDR);
        end
    endtask

    task automatic test_reset_mid;
        bit found;
        lane_tag = 1'b0;
        found = 1'b0;
        drive_start(8'h20, 8'd1);
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (cyc > 0) begin @(posedge clk); #1; start = 1'b0; end
            core_busy = 1'b0; m_ready = 1'b1;
            @(negedge clk);
            if (m_valid && m_lane == 5'd7) begin found = 1'b1; break; end
        end
        start = 1'b0;
        checks++;
        if (!found) begin
            errors++; $display("FAIL rstmid_reach lane 7 not seen, want seen");
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || o_inputmode !== 3'd0 || o_raddr !== 8'h00 || done !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_abort valid %0b busy %0b mode %0d raddr %h done %0b, want 0 0 0 00 0",
                     m_valid, busy, o_inputmode, o_raddr, done);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL rstmid_nodone done %0b busy %0b want 0 0", done, busy);
        end
        rst = 1'b0;
        lane_tag = 1'b1;
        build_exp(8'h30, 1, 1'b1);
        drive_start(8'h30, 8'd1);
        collect(200, 0, 0, 0);
        checks++;
        if (got_data.size() != exp_q.size() || done_cyc != PER_ADDR || got_data[0] !== exp_q[0]) begin
            errors++;
            $display("FAIL rstmid_rerun beats %0d done %0d, want %0d %0d", got_data.size(), done_cyc, exp_q.size(), PER_ADDR);
        end
    endtask

`ifdef RSTREAM_CHECKSUM_EN
    task automatic test_checksum;
        lane_tag = 1'b0;
        drive_start(8'h70, 8'd1);
        collect(200, 0, 0, 0);
        checks++;
        if (got_data.size() != 25) begin
            errors++; $display("FAIL chk_count got %0d want 25", got_data.size());
        end else begin
            checks++;
            if (got_lane[24] !== 5'd31 || got_data[24] !== 64'h0 || got_last[24] !== 1'b1 || got_last[23] !== 1'b0) begin
                errors++;
                $display("FAIL chk_beat lane %0d data %h last %0b lane23_last %0b, want 31 0 1 0",
                         got_lane[24], got_data[24], got_last[24], got_last[23]);
            end
        end
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        test_reset;
        test_single;
        test_core_busy;
        test_backpressure;
        test_multi_wrap;
        test_zero_count;
        test_reset_mid;
`ifdef RSTREAM_CHECKSUM_EN
        test_checksum;
`endif
        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule
